uart_tx_sched: RTL

Packet scheduler sharing the UART transmit path between two byte-stream requesters. Grants the transmitter round-robin, one whole packet at a time. Frames each packet as a header byte carrying the source ID, the payload bytes, then an XOR checksum byte. Sits between game-logic producers and the UART write side (`wr_uart` / `w_data` / `tx_full`), writing only when the TX FIFO has room.

---
 rtl/uart_tx_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler in front of the UART TX FIFO.
// Frames each packet as {HDR_TAG,src}, payload bytes, then an XOR checksum.
module uart_tx_sched #(
  parameter logic [6:0] HDR_TAG = 7'b1010010,
  parameter int         MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       grant,
  output logic       trunc_tick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;
  localparam logic [7:0] CNT_LAST = 8'(MAX_LEN - 1);

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] cnt_q, cnt_d;

  logic       sel_valid;
  logic [7:0] sel_data;
  logic       sel_last;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign sel_last  = grant_q ? req1_last  : req0_last;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    wr_uart      = 1'b0;
    w_data       = 8'h00;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    trunc_tick   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          cnt_d   = 8'h00;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = {HDR_TAG, grant_q};
          chk_d   = {HDR_TAG, grant_q};
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        req0_ready = !grant_q && !tx_full;
        req1_ready = grant_q && !tx_full;
        if (sel_valid && !tx_full) begin
          wr_uart = 1'b1;
          w_data  = sel_data;
          chk_d   = chk_q ^ sel_data;
          // cnt holds at MAX_LEN-1 on close so it never exceeds that bound
          if (sel_last) begin
            state_d = S_CHK;
          end else if (cnt_q == CNT_LAST) begin
            state_d    = S_CHK;
            trunc_tick = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'h01;
          end
        end
      end
      S_CHK: begin
        if (!tx_full) begin
          wr_uart      = 1'b1;
          w_data       = chk_q;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      chk_q        <= 8'h00;
      cnt_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign grant = grant_q;

endmodule
